// File: rtl/uart_bus_arbiter_pkg.sv
// Shared AHB-Lite constants and arbiter FSM state type for the UART bus arbiter.
package uart_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } arb_state_t;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_bus_arbiter_if.sv
// Requester handshake plus AHB-Lite master signals of the UART bus arbiter.
interface uart_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [1:0]          req_valid_i;
  logic [1:0]          req_write_i;
  logic [2*ADDR_W-1:0] req_addr_i;
  logic [63:0]         req_wdata_i;
  logic [1:0]          req_ready_o;
  logic [1:0]          rsp_valid_o;
  logic [31:0]         rsp_rdata_o;
  logic                rsp_err_o;
  logic [ADDR_W-1:0]   HADDR;
  logic                HWRITE;
  logic [1:0]          HTRANS;
  logic [2:0]          HSIZE;
  logic [31:0]         HWDATA;
  logic                HREADY;
  logic [1:0]          HRESP;
  logic [31:0]         HRDATA;
  logic                timeout_o;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    input  HREADY, HRESP, HRDATA,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output HADDR, HWRITE, HTRANS, HSIZE, HWDATA, timeout_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    output HREADY, HRESP, HRDATA,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  HADDR, HWRITE, HTRANS, HSIZE, HWDATA, timeout_o
  );
endinterface

// File: rtl/uart_bus_arbiter_rr_arbiter2.sv
// Two-port round-robin grant; the last-granted pointer starts at port 1 so port 0 wins first.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant,
  output logic       o_idx
);
  logic r_last;

  always_comb begin
    o_grant = '0;
    o_idx   = 1'b0;
    if (i_en) begin
      unique case (i_req)
        2'b01: begin o_grant = 2'b01; o_idx = 1'b0; end
        2'b10: begin o_grant = 2'b10; o_idx = 1'b1; end
        2'b11: begin
          o_idx   = ~r_last;
          o_grant = r_last ? 2'b01 : 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
    end else if (i_en && (|i_req)) begin
      r_last <= o_idx;
    end
  end
endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares one AHB-Lite slave port between two requesters, one single-beat transfer at a time.
module uart_bus_arbiter
  import uart_ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ADDR_W      = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  uart_bus_arbiter_if.master bus
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  arb_state_t        r_state, w_state_nxt;
  logic              r_owner, r_write, r_err, r_timeout;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata;
  logic [15:0]       r_wait;
  logic [1:0]        w_grant;
  logic              w_grant_idx, w_arb_en, w_timeout_hit;

  assign w_arb_en = (r_state == IDLE) && !rst_i;

  rr_arbiter2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_req   (bus.req_valid_i),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  // Timeout is judged on the cycle that would be the TIMEOUT_CYC-th low cycle; HREADY=1 there wins.
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_hit = 1'b0;
    unique case (r_state)
      IDLE: if (|bus.req_valid_i) w_state_nxt = ADDR;
      ADDR: w_state_nxt = DATA;
      DATA: begin
        if (bus.HREADY) begin
          w_state_nxt = DONE;
        end else if (r_wait == TO_LAST) begin
          w_state_nxt   = DONE;
          w_timeout_hit = 1'b1;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o = w_grant;
    bus.HTRANS      = (r_state == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    bus.HADDR       = r_addr;
    bus.HWRITE      = r_write;
    bus.HSIZE       = HSIZE_WORD;
    bus.HWDATA      = ((r_state == DATA) && r_write) ? r_wdata : '0;
    bus.rsp_valid_o = (r_state == DONE) ? port_onehot(r_owner) : '0;
    bus.rsp_rdata_o = (r_state == DONE) ? r_rdata : '0;
    bus.rsp_err_o   = (r_state == DONE) && r_err;
    bus.timeout_o   = r_timeout;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (|bus.req_valid_i) begin
            r_owner <= w_grant_idx;
            r_write <= bus.req_write_i[w_grant_idx];
            r_addr  <= w_grant_idx ? bus.req_addr_i[2*ADDR_W-1:ADDR_W]
                                   : bus.req_addr_i[ADDR_W-1:0];
            r_wdata <= w_grant_idx ? bus.req_wdata_i[63:32] : bus.req_wdata_i[31:0];
            r_wait  <= '0;
          end
        end
        DATA: begin
          if (bus.HREADY) begin
            r_rdata <= r_write ? '0 : bus.HRDATA;
            r_err   <= (bus.HRESP != HRESP_OKAY);
          end else if (w_timeout_hit) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: directed cases plus randomized transfers vs a transaction-level model.
module tb_uart_bus_arbiter;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_last = 1;

  always #5 clk = ~clk;

  uart_bus_arbiter_if #(.ADDR_W(32)) bus ();
  uart_bus_arbiter_if #(.ADDR_W(32)) bus2 ();

  uart_bus_arbiter #(.TIMEOUT_CYC(1024), .ADDR_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  uart_bus_arbiter #(.TIMEOUT_CYC(4), .ADDR_W(32)) dut_to (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet_inputs();
    bus.req_valid_i  = '0; bus.req_write_i = '0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.HREADY       = 1'b1; bus.HRESP = '0; bus.HRDATA = '0;
    bus2.req_valid_i = '0; bus2.req_write_i = '0; bus2.req_addr_i = '0; bus2.req_wdata_i = '0;
    bus2.HREADY      = 1'b1; bus2.HRESP = '0; bus2.HRDATA = 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    quiet_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_i  = 1'b0;
    m_last = 1;
  endtask

  // One transfer on the main DUT: accept, NONSEQ, nwait low cycles then HREADY, response.
  task automatic run_txn(input logic [1:0] pat, input logic [1:0] wr, input logic [63:0] addr,
                         input logic [63:0] wd, input int nwait, input logic [1:0] resp,
                         input logic [31:0] rdat);
    int          w;
    logic [1:0]  oh;
    logic [31:0] e_wd;
    if (pat == 2'b01)      w = 0;
    else if (pat == 2'b10) w = 1;
    else                   w = (m_last == 1) ? 0 : 1;
    m_last = w;
    oh     = (w == 0) ? 2'b01 : 2'b10;
    e_wd   = wr[w] ? wd[w*32 +: 32] : 32'h0;

    @(negedge clk);
    bus.req_valid_i = pat; bus.req_write_i = wr; bus.req_addr_i = addr; bus.req_wdata_i = wd;
    bus.HREADY = 1'b1; bus.HRESP = '0; bus.HRDATA = $urandom;
    #1;
    chk("grant", 64'(bus.req_ready_o), 64'(oh));
    chk("rsp_idle", 64'(bus.rsp_valid_o), 64'h0);

    @(negedge clk);
    #1;
    chk("htrans_nonseq", 64'(bus.HTRANS), 64'h2);
    chk("haddr", 64'(bus.HADDR), 64'(addr[w*32 +: 32]));
    chk("hwrite", 64'(bus.HWRITE), 64'(wr[w]));
    chk("ready_addr", 64'(bus.req_ready_o), 64'h0);

    for (int j = 0; j <= nwait; j++) begin
      @(negedge clk);
      bus.HREADY = (j == nwait);
      bus.HRESP  = (j == nwait) ? resp : 2'b00;
      bus.HRDATA = (j == nwait) ? rdat : $urandom;
      #1;
      chk("htrans_data", 64'(bus.HTRANS), 64'h0);
      chk("hwdata", 64'(bus.HWDATA), 64'(e_wd));
      chk("rsp_wait", 64'(bus.rsp_valid_o), 64'h0);
      chk("ready_data", 64'(bus.req_ready_o), 64'h0);
    end

    @(negedge clk);
    bus.HREADY = 1'b1; bus.HRESP = '0; bus.HRDATA = $urandom;
    #1;
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(oh));
    chk("rsp_rdata", 64'(bus.rsp_rdata_o), wr[w] ? 64'h0 : 64'(rdat));
    chk("rsp_err", 64'(bus.rsp_err_o), 64'(resp != 2'b00));
    chk("ready_done", 64'(bus.req_ready_o), 64'h0);
  endtask

  // Port 0 read on the TIMEOUT_CYC=4 instance with nlow HREADY-low data cycles.
  task automatic t2_txn(input int nlow);
    logic to;
    int   lat;
    to  = (nlow >= 4);
    lat = to ? (2 + 4) : (3 + nlow);
    @(negedge clk);
    bus2.req_valid_i = 2'b01; bus2.req_write_i = 2'b00; bus2.req_addr_i = 64'(32'h0000_0040);
    bus2.HREADY = 1'b1;
    #1;
    chk("t2_grant", 64'(bus2.req_ready_o), 64'h1);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      bus2.req_valid_i = '0;
      if (c >= 2) bus2.HREADY = ((c - 2) == nlow);
      #1;
      if (c < lat) begin
        chk("t2_rsp_wait", 64'(bus2.rsp_valid_o), 64'h0);
      end else begin
        chk("t2_rsp_valid", 64'(bus2.rsp_valid_o), 64'h1);
        chk("t2_rsp_err", 64'(bus2.rsp_err_o), 64'(to));
        chk("t2_rsp_rdata", 64'(bus2.rsp_rdata_o), to ? 64'h0 : 64'hDEAD_BEEF);
        chk("t2_timeout_flag", 64'(bus2.timeout_o), 64'(to));
      end
    end
  endtask

  initial begin
    logic [1:0]  pat;
    logic [1:0]  wr;
    logic [63:0] addr, wd;
    quiet_inputs();
    do_reset();

    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
    chk("rst_rdata", 64'(bus.rsp_rdata_o), 64'h0);
    chk("rst_err", 64'(bus.rsp_err_o), 64'h0);
    chk("rst_htrans", 64'(bus.HTRANS), 64'h0);
    chk("rst_haddr", 64'(bus.HADDR), 64'h0);
    chk("rst_hwrite", 64'(bus.HWRITE), 64'h0);
    chk("rst_hwdata", 64'(bus.HWDATA), 64'h0);
    chk("rst_hsize", 64'(bus.HSIZE), 64'h2);
    chk("rst_timeout", 64'(bus.timeout_o), 64'h0);

    run_txn(2'b01, 2'b00, {32'h0, 32'h0000_0010}, 64'h0, 0, 2'b00, 32'h0000_00A5);

    do_reset();
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, 2'($urandom), {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
              0, 2'b00, $urandom);

    run_txn(2'b10, 2'b10, {32'h0000_0020, 32'h0}, {32'h0000_0055, 32'h0}, 5, 2'b00, $urandom);
    run_txn(2'b01, 2'b01, {32'h0, 32'h0000_0030}, {32'h0, 32'h1234_5678}, 0, 2'b01, 32'hFFFF_FFFF);

    t2_txn(3);
    t2_txn(100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t2_timeout_sticky", 64'(bus2.timeout_o), 64'h1);
    end

    // Reset during DATA: no response for the aborted transfer, pointer back to port 1.
    @(negedge clk);
    bus.req_valid_i = 2'b01; bus.req_write_i = 2'b00; bus.req_addr_i = 64'h44;
    @(negedge clk);
    @(negedge clk);
    bus.HREADY = 1'b0;
    rst_i = 1'b1;
    bus.req_valid_i = '0;
    @(negedge clk);
    #1;
    chk("mid_rst_htrans", 64'(bus.HTRANS), 64'h0);
    chk("mid_rst_rsp", 64'(bus.rsp_valid_o), 64'h0);
    chk("mid_rst_timeout_clr", 64'(bus2.timeout_o), 64'h0);
    rst_i  = 1'b0;
    m_last = 1;
    bus.HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_rsp", 64'(bus.rsp_valid_o), 64'h0);
      chk("post_rst_htrans", 64'(bus.HTRANS), 64'h0);
    end
    run_txn(2'b11, 2'b00, {32'h0000_0200, 32'h0000_0100}, 64'h0, 0, 2'b00, 32'hCAFE_0001);

    for (int i = 0; i < 40; i++) begin
      pat = 2'($urandom_range(0, 3));
      if (pat == 2'b00) begin
        @(negedge clk);
        bus.req_valid_i = '0;
        #1;
        chk("idle_ready", 64'(bus.req_ready_o), 64'h0);
        chk("idle_rsp", 64'(bus.rsp_valid_o), 64'h0);
      end else begin
        wr   = 2'($urandom);
        addr = {32'($urandom), 32'($urandom)};
        wd   = {32'($urandom), 32'($urandom)};
        run_txn(pat, wr, addr, wd, $urandom_range(0, 6), 2'($urandom_range(0, 3)), $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
